sram_rw_port_ctrl: RTL

- Request/response front end for one single-port 1RW SRAM array wrapper (ADDR_W=12, DATA_W=512 geometry).
- Merges an independent write channel and read channel, both valid/ready, onto the single RW0-style port: one op per cycle.
- Captures SRAM read data into a small response FIFO with valid/ready back-pressure.
- Credit-gates reads so returned data is never dropped.

---
 rtl/sram_rw_port_ctrl_if.sv | 33 +++
 rtl/sram_rw_port_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/sram_rw_port_ctrl_if.sv
// rtl/sram_rw_port_ctrl_if.sv - request, response and SRAM-side signal bundle for sram_rw_port_ctrl
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 512
);
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  w_valid, w_addr, w_data, r_valid, r_addr, resp_ready, sram_rdata,
    output w_ready, r_ready, resp_valid, resp_data,
           sram_addr, sram_en, sram_wmode, sram_wdata
  );

  modport master (
    output w_valid, w_addr, w_data, r_valid, r_addr, resp_ready, sram_rdata,
    input  w_ready, r_ready, resp_valid, resp_data,
           sram_addr, sram_en, sram_wmode, sram_wdata
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// rtl/sram_rw_port_ctrl.sv - write/read channel arbiter onto one 1RW SRAM port with credit-gated response FIFO
// Optional macro SRAM_RDATA_REG_EN adds a register stage on sram_rdata ahead of the FIFO.
module sram_rw_port_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 512,
  parameter int RESP_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clock,
  input logic reset,
  sram_rw_port_ctrl_if.slave bus
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 3);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RESP_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(RESP_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [SW-1:0]     starve_cnt;
  logic              rd_pend;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic [1:0]        inflight;
  logic [CW-1:0]     occupancy;
  logic              read_ok;
  logic              starved;
  logic              grant_r;
  logic              grant_w;

  // rd_pend marks a read issued last cycle whose data is on sram_rdata now
`ifdef SRAM_RDATA_REG_EN
  logic              rd_pend_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_pend_q <= 1'b0;
    else       rd_pend_q <= rd_pend;
  end

  always_ff @(posedge clock) begin
    if (rd_pend) rdata_q <= bus.sram_rdata;
  end

  assign push      = rd_pend_q;
  assign push_data = rdata_q;
  assign inflight  = {1'b0, rd_pend} + {1'b0, rd_pend_q};
`else
  assign push      = rd_pend;
  assign push_data = bus.sram_rdata;
  assign inflight  = {1'b0, rd_pend};
`endif

  assign bus.resp_valid = (fifo_cnt != '0);
  assign bus.resp_data  = fifo_mem[rd_ptr];
  assign pop            = bus.resp_valid & bus.resp_ready;

  // Every slot already owed to an issued read counts against the FIFO
  assign occupancy = fifo_cnt + CW'(inflight);
  assign read_ok   = occupancy < (DEPTH_C + CW'(pop));
  assign starved   = starve_cnt >= STARVE_MAX;

  always_comb begin
    grant_r = 1'b0;
    grant_w = 1'b0;
    if (!reset) begin
      if (bus.r_valid && read_ok && (!starved || !bus.w_valid)) grant_r = 1'b1;
      else if (bus.w_valid)                                     grant_w = 1'b1;
    end
  end

  // Readies report the actual grant so at most one is ever high
  always_comb begin
    bus.w_ready    = grant_w;
    bus.r_ready    = grant_r;
    bus.sram_en    = grant_w | grant_r;
    bus.sram_wmode = grant_w;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (grant_w)      bus.sram_addr = bus.w_addr;
    else if (grant_r) bus.sram_addr = bus.r_addr;
    if (grant_w || grant_r) bus.sram_wdata = bus.w_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      rd_pend <= grant_r;
      if (grant_w)                                     starve_cnt <= '0;
      else if (bus.w_valid && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end
endmodule
